sap_datapath: RTL and testbench

SAP-1 datapath: the register/bus side that receives the 12-bit control word from the SAP-1 controller FSM and returns the current 4-bit opcode to it. Contains:
- 4-bit program counter (PC) and memory address register (MAR)
- 16x8 RAM
- instruction register (IR), accumulator A, B register
- add/subtract ALU
- output register, all joined by one 8-bit W-bus

Registers update on the rising clock edge. The controller changes its control word on the falling edge, so the word is stable at every rising edge.

---
 rtl/sap_pkg.sv | 41 ++++
 rtl/sap_ram16x8.sv | 33 +++
 rtl/sap_datapath.sv | 79 +++++++
 tb/tb_sap_datapath.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 datapath: control-word bit positions,
// opcodes, the idle control word and the add/subtract ALU.
package sap_pkg;

  // Control-word bit positions, numbered 12 (Cp) down to 1 (Lo_n).
  localparam int CP   = 12;
  localparam int EP   = 11;
  localparam int LM_N = 10;
  localparam int CE_N = 9;
  localparam int LI_N = 8;
  localparam int EI_N = 7;
  localparam int LA_N = 6;
  localparam int EA   = 5;
  localparam int SU   = 4;
  localparam int EU   = 3;
  localparam int LB_N = 2;
  localparam int LO_N = 1;

  typedef logic [12:1] ctrl_word_t;

  // Idle word: every active-high enable low, every active-low enable high.
  localparam ctrl_word_t NOP = 12'b0011_1110_0011;

  typedef enum logic [3:0] {
    LDA = 4'h0,
    ADD = 4'h1,
    SUB = 4'h2,
    OUT = 4'hE,
    HLT = 4'hF
  } opcode_e;

  // Returns {carry, result}; subtraction is A + ~B + 1, so carry means no borrow.
  function automatic logic [8:0] alu_add_sub(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic       su);
    logic [7:0] b_op;
    b_op = su ? ~b : b;
    return {1'b0, a} + {1'b0, b_op} + {8'h00, su};
  endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// 16x8 program/data RAM: asynchronous read, synchronous write on the
// programming port. Contents survive datapath reset.
module sap_ram16x8 #(
  parameter bit RAM_INIT_ZERO = 1'b1
) (
  input  logic       clock,
  input  logic       wr_en_i,
  input  logic [3:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [3:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  if (RAM_INIT_ZERO) begin : g_init_zero
    logic [7:0] mem_q [16] = '{default: 8'h00};

    // NOTE: the storage array has no reset; only the write port changes it.
    always_ff @(posedge clock) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];
  end else begin : g_init_x
    logic [7:0] mem_q [16];

    always_ff @(posedge clock) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: PC, MAR, IR, A, B and output registers sharing one 8-bit
// W-bus, plus the add/subtract ALU and the program RAM.
module sap_datapath
  import sap_pkg::*;
#(
  parameter bit RAM_INIT_ZERO = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [12:1] controller,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  operation_code,
  output logic [7:0]  out_port,
  output logic [7:0]  w_bus,
  output logic        carry,
  output logic        bus_err
);

  logic [3:0] pc_q, mar_q;
  logic [7:0] ir_q, a_q, b_q, out_q;
  logic [7:0] ram_rd;
  logic [7:0] alu_result;
  logic [4:0] drv_en;

  sap_ram16x8 #(.RAM_INIT_ZERO(RAM_INIT_ZERO)) u_ram (
    .clock    (clock),
    .wr_en_i  (prog_we),
    .wr_addr_i(prog_addr),
    .wr_data_i(prog_data),
    .rd_addr_i(mar_q),
    .rd_data_o(ram_rd)
  );

  assign {carry, alu_result} = alu_add_sub(a_q, b_q, controller[SU]);

  // Active-low enables count only on a literal 0.
  assign drv_en = {controller[EP],
                   controller[CE_N] == 1'b0,
                   controller[EI_N] == 1'b0,
                   controller[EA],
                   controller[EU]};

  // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
  always_comb begin
    w_bus = 8'h00;
    if (drv_en[4]) w_bus = w_bus | {4'h0, pc_q};
    if (drv_en[3]) w_bus = w_bus | ram_rd;
    if (drv_en[2]) w_bus = w_bus | {4'h0, ir_q[3:0]};
    if (drv_en[1]) w_bus = w_bus | a_q;
    if (drv_en[0]) w_bus = w_bus | alu_result;
  end

  assign bus_err = $countones(drv_en) > 1;

  // NOTE: state registers use non-blocking assignments so all loads see the pre-edge bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q  <= 4'h0;
      mar_q <= 4'h0;
      ir_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      out_q <= 8'h00;
    end else begin
      if (controller[CP])          pc_q  <= pc_q + 4'h1;
      if (controller[LM_N] == 1'b0) mar_q <= w_bus[3:0];
      if (controller[LI_N] == 1'b0) ir_q  <= w_bus;
      if (controller[LA_N] == 1'b0) a_q   <= w_bus;
      if (controller[LB_N] == 1'b0) b_q   <= w_bus;
      if (controller[LO_N] == 1'b0) out_q <= a_q;
    end
  end

  assign operation_code = ir_q[7:4];
  assign out_port       = out_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed scenarios plus random
// control words compared against a behavioural model of the datapath.
module tb_sap_datapath;
  import sap_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [12:1] controller = NOP;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'h0;
  logic [7:0]  prog_data = 8'h00;
  logic [3:0]  operation_code;
  logic [7:0]  out_port, w_bus;
  logic        carry, bus_err;

  int tests = 0;
  int fails = 0;

  sap_datapath #(.RAM_INIT_ZERO(1'b1)) dut (
    .clock         (clock),
    .reset         (reset),
    .controller    (controller),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .operation_code(operation_code),
    .out_port      (out_port),
    .w_bus         (w_bus),
    .carry         (carry),
    .bus_err       (bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  // Behavioural model state.
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic [7:0] m_ram [16];
  // Pre-edge samples captured by drive_cycle.
  logic [7:0] pre_bus, exp_bus;
  logic       pre_carry, exp_carry, pre_err, exp_err;

  function automatic ctrl_word_t hi(input int idx);
    return ctrl_word_t'(1) << (idx - 1);
  endfunction

  function automatic ctrl_word_t on(input ctrl_word_t w, input int idx);
    return w | hi(idx);
  endfunction

  function automatic ctrl_word_t low(input ctrl_word_t w, input int idx);
    return w & ~hi(idx);
  endfunction

  // Fetch and instruction control words.
  ctrl_word_t T1, T2, T3, ADR, LDA5, ADD5, ADD6, SUB6, OUT4;
  initial begin
    T1   = low(on(NOP, EP), LM_N);
    T2   = on(NOP, CP);
    T3   = low(low(NOP, CE_N), LI_N);
    ADR  = low(low(NOP, EI_N), LM_N);
    LDA5 = low(low(NOP, CE_N), LA_N);
    ADD5 = low(low(NOP, CE_N), LB_N);
    ADD6 = low(on(NOP, EU), LA_N);
    SUB6 = on(ADD6, SU);
    OUT4 = low(on(NOP, EA), LO_N);
  end

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
  endtask

  // Reference: subtraction as plain difference, carry means A >= B.
  task automatic model_comb(input ctrl_word_t c, output logic [7:0] bus,
                            output logic cy, output logic err);
    int n, sum;
    logic [7:0] alu;
    if (c[SU]) begin
      alu = 8'((int'(m_a) - int'(m_b)) & 255);
      cy  = (m_a >= m_b);
    end else begin
      sum = int'(m_a) + int'(m_b);
      alu = 8'(sum & 255);
      cy  = (sum > 255);
    end
    bus = 8'h00; n = 0;
    if (c[EP] == 1'b1)   begin bus |= {4'h0, m_pc};      n++; end
    if (c[CE_N] == 1'b0) begin bus |= m_ram[m_mar];      n++; end
    if (c[EI_N] == 1'b0) begin bus |= {4'h0, m_ir[3:0]}; n++; end
    if (c[EA] == 1'b1)   begin bus |= m_a;               n++; end
    if (c[EU] == 1'b1)   begin bus |= alu;               n++; end
    err = (n > 1);
  endtask

  // Drives one control word for one clock and advances the model; no checks here.
  task automatic drive_cycle(input ctrl_word_t c);
    logic [7:0] old_a;
    @(negedge clock);
    controller = c;
    #1;
    pre_bus = w_bus; pre_carry = carry; pre_err = bus_err;
    model_comb(c, exp_bus, exp_carry, exp_err);
    @(posedge clock);
    if (!reset) model_reset();
    else begin
      old_a = m_a;
      if (c[CP] == 1'b1)   m_pc  = m_pc + 4'd1;
      if (c[LM_N] == 1'b0) m_mar = exp_bus[3:0];
      if (c[LI_N] == 1'b0) m_ir  = exp_bus;
      if (c[LA_N] == 1'b0) m_a   = exp_bus;
      if (c[LB_N] == 1'b0) m_b   = exp_bus;
      if (c[LO_N] == 1'b0) m_out = old_a;
    end
    if (prog_we) m_ram[prog_addr] = prog_data;
    #1;
  endtask

  task automatic program_ram(input logic [7:0] img [16]);
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
      drive_cycle(NOP);
    end
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    drive_cycle(NOP);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ctrl_word_t all_on;
    all_on = 12'hC14;
    reset = 1'b0;
    model_reset();
    drive_cycle(all_on);
    drive_cycle(all_on);
    tests++;
    if ({dut.pc_q, dut.mar_q, dut.ir_q, dut.a_q, dut.b_q, out_port} !== 40'h0) begin
      fails++;
      $display("FAIL reset_regs: got pc=%h mar=%h ir=%h a=%h b=%h out=%h, required all 0",
               dut.pc_q, dut.mar_q, dut.ir_q, dut.a_q, dut.b_q, out_port);
    end
    tests++;
    if (operation_code !== 4'h0) begin
      fails++; $display("FAIL reset_opcode: got %h required 0", operation_code);
    end
  endtask

  task automatic test_fetch();
    logic [7:0] img [16];
    img = '{default: 8'h00};
    img[0] = 8'h09;
    program_ram(img);
    release_reset();
    drive_cycle(T1);
    tests++;
    if (dut.mar_q !== 4'h0) begin
      fails++; $display("FAIL fetch_t1_mar: got %h required 0", dut.mar_q);
    end
    drive_cycle(T2);
    tests++;
    if (dut.pc_q !== 4'h1) begin
      fails++; $display("FAIL fetch_t2_pc: got %h required 1", dut.pc_q);
    end
    drive_cycle(T3);
    tests++;
    if (dut.ir_q !== 8'h09 || operation_code !== 4'h0) begin
      fails++; $display("FAIL fetch_t3_ir: got ir=%h op=%h required ir=09 op=0", dut.ir_q, operation_code);
    end
  endtask

  task automatic fetch();
    drive_cycle(T1); drive_cycle(T2); drive_cycle(T3);
  endtask

  task automatic test_program();
    logic [7:0] img [16];
    img = '{default: 8'h00};
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h2B; img[3] = 8'hE0; img[4] = 8'hF0;
    img[9] = 8'h10; img[10] = 8'h14; img[11] = 8'h18;
    do_reset();
    program_ram(img);
    release_reset();
    fetch(); drive_cycle(ADR); drive_cycle(LDA5); drive_cycle(NOP);
    tests++;
    if (dut.a_q !== 8'h10) begin
      fails++; $display("FAIL prog_lda: got A=%h required 10", dut.a_q);
    end
    fetch();
    tests++;
    if (operation_code !== ADD) begin
      fails++; $display("FAIL prog_add_opcode: got %h required 1", operation_code);
    end
    drive_cycle(ADR); drive_cycle(ADD5); drive_cycle(ADD6);
    tests++;
    if (dut.a_q !== 8'h24) begin
      fails++; $display("FAIL prog_add: got A=%h required 24", dut.a_q);
    end
    fetch(); drive_cycle(ADR); drive_cycle(ADD5); drive_cycle(SUB6);
    tests++;
    if (dut.a_q !== 8'h0C || pre_carry !== 1'b1) begin
      fails++; $display("FAIL prog_sub: got A=%h carry=%b required A=0c carry=1", dut.a_q, pre_carry);
    end
    fetch(); drive_cycle(OUT4);
    tests++;
    if (out_port !== 8'h0C || operation_code !== OUT) begin
      fails++; $display("FAIL prog_out: got out=%h op=%h required out=0c op=e", out_port, operation_code);
    end
    fetch();
    tests++;
    if (operation_code !== HLT) begin
      fails++; $display("FAIL prog_hlt_opcode: got %h required f", operation_code);
    end
  endtask

  task automatic test_sub_underflow();
    logic [7:0] img [16];
    img = '{default: 8'h00};
    img[0] = 8'h05; img[1] = 8'h07;
    do_reset();
    program_ram(img);
    release_reset();
    drive_cycle(T1); drive_cycle(LDA5); drive_cycle(T2);
    drive_cycle(T1); drive_cycle(ADD5);
    drive_cycle(on(on(NOP, SU), EU));
    tests++;
    if (pre_bus !== 8'hFE || pre_carry !== 1'b0 || pre_err !== 1'b0) begin
      fails++; $display("FAIL sub_underflow: got bus=%h carry=%b err=%b required bus=fe carry=0 err=0",
                        pre_bus, pre_carry, pre_err);
    end
  endtask

  task automatic test_bus_conflict_wrap();
    logic [7:0] img [16];
    img = '{default: 8'h00};
    img[0] = 8'hF0;
    do_reset();
    program_ram(img);
    release_reset();
    drive_cycle(T1); drive_cycle(LDA5);
    for (int i = 0; i < 3; i++) drive_cycle(T2);
    drive_cycle(on(on(NOP, EP), EA));
    tests++;
    if (pre_bus !== 8'hF3 || pre_err !== 1'b1) begin
      fails++; $display("FAIL bus_conflict: got bus=%h err=%b required bus=f3 err=1", pre_bus, pre_err);
    end
    drive_cycle(on(on(NOP, EP), CP));
    tests++;
    if (pre_bus !== 8'h03 || dut.pc_q !== 4'h4 || pre_err !== 1'b0) begin
      fails++; $display("FAIL cp_ep_same: got bus=%h pc=%h err=%b required bus=03 pc=4 err=0",
                        pre_bus, dut.pc_q, pre_err);
    end
    do_reset();
    release_reset();
    for (int i = 0; i < 15; i++) drive_cycle(T2);
    tests++;
    if (dut.pc_q !== 4'hF) begin
      fails++; $display("FAIL pc_15: got %h required f", dut.pc_q);
    end
    drive_cycle(T2);
    tests++;
    if (dut.pc_q !== 4'h0) begin
      fails++; $display("FAIL pc_wrap: got %h required 0", dut.pc_q);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] img [16];
    img = '{default: 8'h00};
    img[0] = 8'h09; img[1] = 8'h1A; img[9] = 8'h10; img[10] = 8'h14;
    do_reset();
    program_ram(img);
    release_reset();
    fetch(); drive_cycle(ADR); drive_cycle(LDA5); drive_cycle(NOP);
    fetch(); drive_cycle(ADR); drive_cycle(ADD5);
    @(negedge clock);
    controller = ADD6;
    #1;
    tests++;
    if (dut.a_q !== 8'h10) begin
      fails++; $display("FAIL midop_pre: got A=%h required 10", dut.a_q);
    end
    reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dut.a_q !== 8'h00 || operation_code !== 4'h0 || dut.pc_q !== 4'h0) begin
      fails++; $display("FAIL midop_async_clear: got A=%h op=%h pc=%h required 0 0 0",
                        dut.a_q, operation_code, dut.pc_q);
    end
    drive_cycle(NOP);
    release_reset();
    fetch(); drive_cycle(ADR); drive_cycle(LDA5);
    tests++;
    if (pre_bus !== 8'h10 || dut.a_q !== 8'h10) begin
      fails++; $display("FAIL midop_ram_kept: got bus=%h A=%h required 10 10", pre_bus, dut.a_q);
    end
  endtask

  task automatic test_random();
    logic [7:0] img [16];
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    do_reset();
    program_ram(img);
    release_reset();
    for (int n = 0; n < 400; n++) begin
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = 4'($urandom);
      prog_data = 8'($urandom);
      drive_cycle(ctrl_word_t'($urandom));
      tests++;
      if (pre_bus !== exp_bus || pre_carry !== exp_carry || pre_err !== exp_err) begin
        fails++; $display("FAIL rand_comb[%0d]: got bus=%h c=%b e=%b required bus=%h c=%b e=%b",
                          n, pre_bus, pre_carry, pre_err, exp_bus, exp_carry, exp_err);
      end
      tests++;
      if ({dut.pc_q, dut.mar_q, dut.ir_q, dut.a_q, dut.b_q, out_port, operation_code} !==
          {m_pc, m_mar, m_ir, m_a, m_b, m_out, m_ir[7:4]}) begin
        fails++; $display("FAIL rand_regs[%0d]: got pc=%h mar=%h ir=%h a=%h b=%h out=%h required pc=%h mar=%h ir=%h a=%h b=%h out=%h",
                          n, dut.pc_q, dut.mar_q, dut.ir_q, dut.a_q, dut.b_q, out_port,
                          m_pc, m_mar, m_ir, m_a, m_b, m_out);
      end
    end
    prog_we = 1'b0;
  endtask

  initial begin
    m_ram = '{default: 8'h00};
    model_reset();
    test_reset();
    test_fetch();
    test_program();
    test_sub_underflow();
    test_bus_conflict_wrap();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
